// File: rtl/dlx_mem_pkg.sv
// dlx_mem_pkg
// Types and helpers shared by the DLX data-memory master and the load data
// extender (which the instruction fetch path also uses).
//   mem_size_t   : core request size encoding (req_size)
//   mem_err_t    : response error codes (rsp_err_code)
//   mst_state_t  : memory master FSM states
//   AddrCode*    : size codes placed in the low two bits of the memory ADDRESS
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISALIGN = 2'b01,
        TIMEOUT  = 2'b10,
        BADSIZE  = 2'b11
    } mem_err_t;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StAccess,
        StResp
    } mst_state_t;

    // The memory picks the byte lane from these codes, not from the address offset.
    localparam logic [1:0] AddrCodeByte = 2'b01;
    localparam logic [1:0] AddrCodeHalf = 2'b10;
    localparam logic [1:0] AddrCodeWord = 2'b00;

    function automatic logic [1:0] addr_code(input mem_size_t size);
        logic [1:0] code;
        case (size)
            BYTE:    code = AddrCodeByte;
            HALF:    code = AddrCodeHalf;
            default: code = AddrCodeWord;
        endcase
        return code;
    endfunction

    // Request validation in priority order: bad size first, then alignment.
    // Bytes must be word aligned because the low address bits carry the size code.
    function automatic mem_err_t check_request(input mem_size_t size, input logic [1:0] offset);
        mem_err_t err;
        case (size)
            RSVD:    err = BADSIZE;
            HALF:    err = offset[0] ? MISALIGN : NONE;
            default: err = (offset != 2'b00) ? MISALIGN : NONE;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dlx_mem_extend.sv
// dlx_mem_extend
// Combinational load data extender, shared with the instruction fetch path.
// Ports:
//   size_i   : access size (byte / half / word)
//   signed_i : sign-extend byte and half loads when set, zero-extend otherwise
//   data_i   : raw data from the memory bus, right-aligned
//   rdata_o  : extended load data; words pass through unchanged
module dlx_mem_extend
    import dlx_mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32
) (
    input  mem_size_t              size_i,
    input  logic                   signed_i,
    input  logic [WORD_SIZE-1:0]   data_i,
    output logic [WORD_SIZE-1:0]   rdata_o
);

    logic byte_fill;
    logic half_fill;

    // Unknown read data is propagated as-is rather than being masked.
    assign byte_fill = signed_i & data_i[7];
    assign half_fill = signed_i & data_i[15];

    always_comb begin
        rdata_o = data_i;
        case (size_i)
            BYTE:    rdata_o = {{(WORD_SIZE - 8){byte_fill}}, data_i[7:0]};
            HALF:    rdata_o = {{(WORD_SIZE - 16){half_fill}}, data_i[15:0]};
            default: rdata_o = data_i;
        endcase
    end

endmodule

// File: rtl/dlx_mem_master.sv
// dlx_mem_master
// Initiator side of the DLX memory interface (ENABLE / READNOTWRITE / ADDRESS /
// INOUT_DATA / DATA_READY). Takes one load/store at a time from the core,
// validates it, runs the memory handshake and returns extended read data or an
// error code.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req_*                : core request (valid/ready), size, sign, address, store data
//   rsp_*                : response (valid/ready), read data, error flag and code
//   mem_enable           : memory ENABLE
//   mem_readnotwrite     : memory READNOTWRITE
//   mem_address          : memory ADDRESS with the size code in bits [1:0]
//   mem_data_out/_oe     : store data and tristate enable toward INOUT_DATA
//   mem_data_in          : INOUT_DATA as seen by the master
//   mem_data_ready       : memory DATA_READY (sticky between accesses)
//   busy                 : FSM is not idle
module dlx_mem_master
    import dlx_mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned ADDRESS_SIZE   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]    req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WORD_SIZE-1:0]    rsp_rdata,
    output logic                    rsp_err,
    output logic [1:0]              rsp_err_code,
    output logic                    mem_enable,
    output logic                    mem_readnotwrite,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]    mem_data_out,
    output logic                    mem_data_oe,
    input  logic [WORD_SIZE-1:0]    mem_data_in,
    input  logic                    mem_data_ready,
    output logic                    busy
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES);

    mst_state_t state_q, state_d;

    // Registered request
    logic                    we_q, we_d;
    mem_size_t               size_q, size_d;
    logic                    signed_q, signed_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    wdata_q, wdata_d;

    // Memory side
    logic [ADDRESS_SIZE-1:0] mem_address_q, mem_address_d;
    logic [WORD_SIZE-1:0]    mem_data_out_q, mem_data_out_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    // Response side
    logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
    logic                    err_q, err_d;
    mem_err_t                code_q, code_d;

    mem_err_t                chk_err;
    logic [WORD_SIZE-1:0]    padded_wdata;
    logic [WORD_SIZE-1:0]    ext_rdata;

    assign chk_err = check_request(size_q, addr_q[1:0]);

    // Store data is right-aligned and zero-padded above the access size.
    always_comb begin
        padded_wdata = '0;
        case (size_q)
            BYTE:    padded_wdata[7:0]  = wdata_q[7:0];
            HALF:    padded_wdata[15:0] = wdata_q[15:0];
            default: padded_wdata       = wdata_q;
        endcase
    end

    dlx_mem_extend #(
        .WORD_SIZE (WORD_SIZE)
    ) u_extend (
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_i   (mem_data_in),
        .rdata_o  (ext_rdata)
    );

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        size_d         = size_q;
        signed_d       = signed_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        code_d         = code_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = mem_size_t'(req_size);
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    state_d  = StCheck;
                end
            end

            StCheck: begin
                if (chk_err != NONE) begin
                    err_d   = 1'b1;
                    code_d  = chk_err;
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    mem_address_d  = {addr_q[ADDRESS_SIZE-1:2], addr_code(size_q)};
                    mem_data_out_d = padded_wdata;
                    cnt_d          = CntOne;
                    state_d        = StAccess;
                end
            end

            StAccess: begin
                // DATA_READY may still be high from the previous access, so the
                // first ACCESS cycle never completes.
                if ((cnt_q != CntOne) && mem_data_ready) begin
                    rdata_d = we_q ? '0 : ext_rdata;
                    err_d   = 1'b0;
                    code_d  = NONE;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    code_d  = TIMEOUT;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StResp: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    code_d  = NONE;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            we_q           <= 1'b0;
            size_q         <= BYTE;
            signed_q       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            cnt_q          <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            code_q         <= NONE;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            cnt_q          <= cnt_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            code_q         <= code_d;
        end
    end

    // Control outputs decode the registered state only, so request inputs never
    // reach the memory bus combinationally.
    assign req_ready        = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign rsp_valid        = (state_q == StResp);
    assign mem_enable       = (state_q == StAccess);
    assign mem_readnotwrite = ~(mem_enable & we_q);
    assign mem_data_oe      = mem_enable & we_q;
    assign mem_address      = mem_address_q;
    assign mem_data_out     = mem_data_out_q;
    assign rsp_rdata        = rdata_q;
    assign rsp_err          = err_q;
    assign rsp_err_code     = code_q;

endmodule

// File: doc/dlx_mem_master.md
Name: dlx_mem_master

Overview:
- Initiator end of the team's memory interface (ENABLE / READNOTWRITE / ADDRESS / INOUT_DATA / DATA_READY), which the DLX load/store path uses to talk to the read/write data memory model.
- Accepts one load/store request at a time from the core through a valid/ready handshake.
- Encodes access size into the low address bits, drives the memory handshake, and sign- or zero-extends read data.
- Returns read data or an error (misaligned, bad size, timeout) through a valid/ready response port.

Parameters:
WORD_SIZE, 32, data width in bits; only 32 is supported.
ADDRESS_SIZE, 16, width of both the core byte address and the memory ADDRESS bus.
TIMEOUT_CYCLES, 16, number of ENABLE cycles without DATA_READY before the access is aborted; must be >= 2.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  sign-extend loads of byte or half
req_addr  in  ADDRESS_SIZE  byte address
req_wdata  in  WORD_SIZE  store data, right-aligned
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_rdata  out  WORD_SIZE  extended load data; 0 for stores and errors
rsp_err  out  1  request failed
rsp_err_code  out  2  00 none, 01 misaligned, 10 timeout, 11 bad size
mem_enable  out  1  memory ENABLE
mem_readnotwrite  out  1  memory READNOTWRITE
mem_address  out  ADDRESS_SIZE  memory ADDRESS
mem_data_out  out  WORD_SIZE  write data toward INOUT_DATA
mem_data_oe  out  1  tristate enable; the bench wrapper resolves INOUT_DATA
mem_data_in  in  WORD_SIZE  INOUT_DATA as seen by the master
mem_data_ready  in  1  memory DATA_READY
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate) puts the FSM in IDLE with these output values:
  - mem_enable=0, mem_readnotwrite=1, mem_data_oe=0, mem_address=0, mem_data_out=0
  - rsp_valid=0, rsp_err=0, rsp_err_code=00, rsp_rdata=0
  - req_ready=1, busy=0
- Reset during an access abandons it silently; no response is produced.
- FSM states: IDLE, CHECK, ACCESS, RESP.
- IDLE: on req_valid && req_ready, register all request fields and go to CHECK. There is no combinational path from request inputs to memory outputs.
- CHECK (1 cycle), errors in priority order:
  - req_size=11 -> bad size (11), then RESP.
  - half with addr[0]=1, or word with addr[1:0]!=00 -> misaligned (01), then RESP.
  - byte with addr[1:0]!=00 -> misaligned. The memory selects the lane by size code, not by offset.
  - Otherwise go to ACCESS. An errored request never asserts mem_enable.
- mem_address = {addr[ADDRESS_SIZE-1:2], code}, with code 01 for byte, 10 for half, 00 for word.
- Store data is zero-padded: byte -> {24'h0, wdata[7:0]}; half -> {16'h0, wdata[15:0]}; word -> wdata.
- ACCESS:
  - mem_enable=1 and mem_readnotwrite=~we. mem_address and mem_data_out are held stable.
  - mem_data_oe=we for the whole state.
  - A cycle counter starts at 1 on the first ACCESS cycle.
  - DATA_READY from the memory is sticky across accesses, so mem_data_ready is ignored on the first ACCESS cycle and sampled from cycle 2 onward.
  - When it is sampled high: capture mem_data_in (loads), deassert enable and oe on the next edge, go to RESP. Minimum ACCESS length is 2 cycles.
  - If the counter reaches TIMEOUT_CYCLES without sampled ready: go to RESP with code 10 and rdata 0.
- Load extension:
  - byte: data_in[7:0], sign-extended if signed, else zero-extended.
  - half: data_in[15:0], same rule.
  - word: unchanged.
  - Read data that is X or Z is passed through unchanged; the bench checks it.
- RESP: rsp_valid=1 and all rsp fields held until rsp_ready. On the handshake edge go to IDLE, clear rsp_valid, and raise req_ready.
- A new request can be accepted in the cycle after the response handshake. Back-to-back throughput is one access per 5 cycles minimum (IDLE, CHECK, ACCESS x2, RESP).
- rsp_ready held high while not in RESP has no effect.

Decomposition:
- Package dlx_mem_pkg holds:
  - typedef enum mem_size_t {BYTE, HALF, WORD, RSVD}
  - typedef enum mem_err_t {NONE, MISALIGN, TIMEOUT, BADSIZE}
  - typedef enum for FSM states
  - localparams for the size codes on mem_address (01, 10, 00)
- One natural sub-module: dlx_mem_extend, the combinational load data extender (size, signed, data_in -> rdata). It is reused by the instruction fetch path.

Test Plan:
- Word store 0xDEADBEEF to addr 0x0010, then word load of 0x0010 -> mem_address 0x0010 on both accesses, oe high only for the store, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte load, addr 0x0020, memory word 0x000000F0: signed -> 0xFFFFFFF0 with mem_address 0x0021; unsigned -> 0x000000F0.
- Half store 0x1234ABCD to addr 0x0030 -> mem_data_out=0x0000ABCD and mem_address 0x0032.
- Misaligned word load at 0x0006, then a request with req_size=11 -> err codes 01 and 11, mem_enable never asserted.
- Memory model holding DATA_READY low -> mem_enable high for exactly 16 cycles, then rsp_err=1, code 10, rdata 0.
- Assert rst in ACCESS cycle 1 with rsp_ready tied low -> all outputs at reset values within the same cycle, no rsp_valid ever, and the next request completes normally.
